// File: rtl/mmm_pkg.sv
// ---------------------------------------------------------------------------
// mmm_pkg
// Shared width helpers and default operand geometry for the Montgomery
// modular multiplier datapath and the RSA top.
//   ndig(width, digit) : number of digits needed to cover an operand
//   cnt_w(n)           : bits needed to hold a counter value 0..n
// ---------------------------------------------------------------------------
package mmm_pkg;

    localparam int WIDTH_DEF = 10;
    localparam int DIGIT_DEF = 1;

    // Ceiling division: a partial top digit still costs a full step.
    function automatic int ndig(input int width, input int digit);
        return (width + digit - 1) / digit;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shiftreg_digit_if.sv
// ---------------------------------------------------------------------------
// shiftreg_digit_if
// Operand bus between the MMM controller (master) and the operand
// serialiser (slave).
//   en       : step enable, qualifies both ld_a and the shift
//   ld_a     : load request, acted on only when en=1
//   A        : operand to load (WIDTH bits)
//   A_digit  : current digit (DIGIT bits)
//   busy     : digits remain
//   last     : the digit on A_digit is the final one
//   done     : one-cycle pulse after the final digit is consumed
//
// Handshake: there is no ready signal. Every clk edge with en=1 is one
// accepted step; the slave always accepts. A step with ld_a=1 loads, a step
// with ld_a=0 consumes the digit currently on A_digit (if busy).
// ---------------------------------------------------------------------------
interface shiftreg_digit_if #(
    parameter int WIDTH = 10,
    parameter int DIGIT = 1
);
    logic             en;
    logic             ld_a;
    logic [WIDTH-1:0] A;
    logic [DIGIT-1:0] A_digit;
    logic             busy;
    logic             last;
    logic             done;

    modport master (
        output en, ld_a, A,
        input  A_digit, busy, last, done
    );

    modport slave (
        input  en, ld_a, A,
        output A_digit, busy, last, done
    );
endinterface

// File: rtl/digit_counter.sv
// ---------------------------------------------------------------------------
// digit_counter
// Loadable down-counter with zero/one detect and a registered terminal pulse.
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   clr_n_i  in   synchronous active-low clear (wins over load/dec)
//   load_i   in   load N (wins over dec)
//   dec_i    in   decrement when non-zero
//   cnt_o    out  current count
//   zero_o   out  count == 0
//   one_o    out  count == 1
//   term_o   out  one-cycle pulse after a decrement from 1 to 0
// ---------------------------------------------------------------------------
module digit_counter #(
    parameter int N  = 10,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_n_i,
    input  logic          load_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o,
    output logic          one_o,
    output logic          term_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          term_q, term_d;

    // term_d defaults to 0 so the pulse always lasts exactly one cycle,
    // even when the next cycle is not enabled.
    always_comb begin
        cnt_d  = cnt_q;
        term_d = 1'b0;
        if (!clr_n_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CW'(N);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d  = cnt_q - CW'(1);
            term_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            term_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == CW'(1));
    assign term_o = term_q;

endmodule

// File: rtl/shiftreg_digit.sv
// ---------------------------------------------------------------------------
// shiftreg_digit
// Operand serialiser: loads a WIDTH-bit operand and presents it DIGIT bits
// per enabled step, LSB-first (MSB_FIRST=0) or MSB-first (MSB_FIRST=1).
//   clk        in   clock
//   rstb       in   asynchronous active-low reset
//   rst_mmm_i  in   synchronous active-low clear, ignores en
//   bus        slave modport of shiftreg_digit_if (en, ld_a, A, A_digit,
//              busy, last, done)
//   cnt_o      out  digits remaining (debug view of the digit counter)
// ---------------------------------------------------------------------------
module shiftreg_digit
    import mmm_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DIGIT     = DIGIT_DEF,
    parameter int MSB_FIRST = 0
) (
    input  logic                                      clk,
    input  logic                                      rstb,
    input  logic                                      rst_mmm_i,
    shiftreg_digit_if.slave                           bus,
    output logic [cnt_w(ndig(WIDTH, DIGIT))-1:0]      cnt_o
);

    localparam int NDIG  = ndig(WIDTH, DIGIT);
    localparam int REG_W = NDIG * DIGIT;
    localparam int CW    = cnt_w(NDIG);

    logic [REG_W-1:0] data_q, data_d;
    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             cnt_one;
    logic             term;
    logic             load_w;
    logic             shift_w;

    assign load_w  = bus.en & bus.ld_a;
    assign shift_w = bus.en & ~bus.ld_a & ~cnt_zero;

    digit_counter #(
        .N  (NDIG),
        .CW (CW)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rstb),
        .clr_n_i (rst_mmm_i),
        .load_i  (load_w),
        .dec_i   (bus.en),
        .cnt_o   (cnt),
        .zero_o  (cnt_zero),
        .one_o   (cnt_one),
        .term_o  (term)
    );

    // Zero fill on every shift means the register is all-zero once the
    // last digit is consumed, so A_digit reads 0 while idle.
    always_comb begin
        data_d = data_q;
        if (!rst_mmm_i) begin
            data_d = '0;
        end else if (load_w) begin
            data_d            = '0;
            data_d[WIDTH-1:0] = bus.A;
        end else if (shift_w) begin
            if (MSB_FIRST != 0) begin
                data_d = data_q << DIGIT;
            end else begin
                data_d = data_q >> DIGIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    // MSB-first with padding: the top digit carries the pad zeros.
    assign bus.A_digit = (MSB_FIRST != 0) ? data_q[REG_W-1 -: DIGIT]
                                          : data_q[DIGIT-1:0];
    assign bus.busy    = ~cnt_zero;
    assign bus.last    = cnt_one;
    assign bus.done    = term;
    assign cnt_o       = cnt;

endmodule

// File: tb/tb_shiftreg_digit.sv
module tb_shiftreg_digit;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic rst_mmm = 1'b1;
  logic en = 1'b0;
  logic ld_a = 1'b0;
  logic [9:0] a_op = '0;
  logic [3:0] cnt1;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;

  // reference model: operand value plus digits remaining; the expected digit
  // is picked out of the original operand by its index
  logic [11:0] m1_val = '0;
  logic [11:0] m2_val = '0;
  int m1_cnt = 0;
  int m2_cnt = 0;
  bit m1_done = 0;
  bit m2_done = 0;

  shiftreg_digit_if #(.WIDTH(10), .DIGIT(1)) if1 ();
  shiftreg_digit_if #(.WIDTH(10), .DIGIT(4)) if2 ();

  assign if1.en = en;
  assign if1.ld_a = ld_a;
  assign if1.A = a_op;
  assign if2.en = en;
  assign if2.ld_a = ld_a;
  assign if2.A = a_op;

  shiftreg_digit #(.WIDTH(10), .DIGIT(1), .MSB_FIRST(0)) dut1 (
    .clk(clk), .rstb(rstb), .rst_mmm_i(rst_mmm), .bus(if1), .cnt_o(cnt1)
  );

  shiftreg_digit #(.WIDTH(10), .DIGIT(4), .MSB_FIRST(1)) dut2 (
    .clk(clk), .rstb(rstb), .rst_mmm_i(rst_mmm), .bus(if2), .cnt_o(cnt2)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_dig(logic [11:0] val, int cnt, int n, int d, bit msb);
    int k;
    int mask;
    logic [11:0] s;
    if (cnt == 0) return 32'd0;
    k = msb ? (cnt - 1) : (n - cnt);
    s = val >> (k * d);
    mask = (1 << d) - 1;
    return 32'(s) & mask;
  endfunction

  task automatic do_chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic upd(inout logic [11:0] val, inout int cnt, inout bit dn, input int n);
    dn = 0;
    if (!rst_mmm) begin
      val = '0;
      cnt = 0;
    end else if (en && ld_a) begin
      val = {2'b00, a_op};
      cnt = n;
    end else if (en && cnt > 0) begin
      cnt--;
      if (cnt == 0) dn = 1;
    end
  endtask

  task automatic model_async_reset();
    m1_val = '0; m1_cnt = 0; m1_done = 0;
    m2_val = '0; m2_cnt = 0; m2_done = 0;
  endtask

  task automatic check(input string tag);
    do_chk({tag, ".d1.digit"}, 32'(if1.A_digit), exp_dig(m1_val, m1_cnt, 10, 1, 0));
    do_chk({tag, ".d1.busy"}, 32'(if1.busy), 32'(m1_cnt != 0));
    do_chk({tag, ".d1.last"}, 32'(if1.last), 32'(m1_cnt == 1));
    do_chk({tag, ".d1.done"}, 32'(if1.done), 32'(m1_done));
    do_chk({tag, ".d1.cnt"}, 32'(cnt1), 32'(m1_cnt));
    do_chk({tag, ".d1.last_done"}, 32'(if1.last & if1.done), 32'd0);
    do_chk({tag, ".d2.digit"}, 32'(if2.A_digit), exp_dig(m2_val, m2_cnt, 3, 4, 1));
    do_chk({tag, ".d2.busy"}, 32'(if2.busy), 32'(m2_cnt != 0));
    do_chk({tag, ".d2.last"}, 32'(if2.last), 32'(m2_cnt == 1));
    do_chk({tag, ".d2.done"}, 32'(if2.done), 32'(m2_done));
    do_chk({tag, ".d2.cnt"}, 32'(cnt2), 32'(m2_cnt));
    do_chk({tag, ".d2.last_done"}, 32'(if2.last & if2.done), 32'd0);
  endtask

  // driver: one clock edge, model update, sample 1 time unit later
  task automatic cycle(input string tag);
    @(posedge clk);
    upd(m1_val, m1_cnt, m1_done, 10);
    upd(m2_val, m2_cnt, m2_done, 3);
    #1;
    check(tag);
  endtask

  task automatic drive(input logic e, input logic l, input logic [9:0] a);
    en = e;
    ld_a = l;
    a_op = a;
  endtask

  initial begin : main
    logic [3:0] seq1 [10];
    logic [3:0] seq2 [3];
    int dn_cnt;
    int dn_at;
    seq1 = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1};
    seq2 = '{4'h2, 4'hD, 4'h5};

    // reset
    #2;
    check("reset");
    #10;
    rstb = 1'b1;

    // load 0x2D5 and walk all digits, with explicit digit sequences
    drive(1, 1, 10'h2D5);
    cycle("load1");
    drive(1, 0, 10'h000);
    for (int i = 0; i < 10; i++) begin
      do_chk($sformatf("seq1[%0d]", i), 32'(if1.A_digit), 32'(seq1[i]));
      do_chk($sformatf("seq1.last[%0d]", i), 32'(if1.last), 32'(i == 9));
      if (i < 3) do_chk($sformatf("seq2[%0d]", i), 32'(if2.A_digit), 32'(seq2[i]));
      cycle("shift1");
      if (i == 2) do_chk("seq2.done", 32'(if2.done), 32'd1);
    end
    do_chk("seq1.done", 32'(if1.done), 32'd1);

    // idle enabled steps after completion
    for (int i = 0; i < 5; i++) begin
      cycle("idle");
      do_chk("idle.done", 32'(if1.done), 32'd0);
    end

    // en toggling
    drive(1, 1, 10'h3FF);
    cycle("load_tog");
    dn_cnt = 0;
    dn_at = -1;
    for (int c = 0; c < 20; c++) begin
      drive((c % 2) == 0, 0, 10'h000);
      cycle("toggle");
      if (if1.done) begin
        dn_cnt++;
        dn_at = c;
      end
    end
    do_chk("toggle.done_count", 32'(dn_cnt), 32'd1);
    do_chk("toggle.done_at", 32'(dn_at), 32'd18);

    // reload mid-operand
    drive(1, 1, 10'h155);
    cycle("load_155");
    drive(1, 0, 10'h000);
    dn_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle("shift_155");
      if (if1.done) dn_cnt++;
    end
    drive(1, 1, 10'h0AA);
    cycle("reload_0AA");
    do_chk("reload.cnt", 32'(cnt1), 32'd10);
    do_chk("reload.digit0", 32'(if1.A_digit), 32'd0);
    drive(1, 0, 10'h000);
    for (int i = 0; i < 10; i++) begin
      cycle("shift_0AA");
      if (if1.done) dn_cnt++;
    end
    do_chk("reload.done_count", 32'(dn_cnt), 32'd1);

    // load on the final-shift step
    drive(1, 1, 10'h2D5);
    cycle("load_fin");
    drive(1, 0, 10'h000);
    for (int i = 0; i < 9; i++) cycle("shift_fin");
    do_chk("fin.last", 32'(if1.last), 32'd1);
    drive(1, 1, 10'h155);
    cycle("load_on_final");
    do_chk("fin.done", 32'(if1.done), 32'd0);
    do_chk("fin.cnt", 32'(cnt1), 32'd10);

    // asynchronous reset between edges
    drive(1, 0, 10'h000);
    for (int i = 0; i < 3; i++) cycle("pre_rstb");
    #2;
    rstb = 1'b0;
    #1;
    model_async_reset();
    check("rstb_async");
    do_chk("rstb.busy", 32'(if1.busy), 32'd0);
    #1;
    rstb = 1'b1;
    cycle("post_rstb");

    // synchronous clear with en low
    drive(1, 1, 10'h3FF);
    cycle("load_clr");
    drive(1, 0, 10'h000);
    for (int i = 0; i < 3; i++) cycle("pre_clr");
    drive(0, 0, 10'h000);
    rst_mmm = 1'b0;
    #2;
    check("clr_before_edge");
    cycle("clr_edge");
    do_chk("clr.cnt", 32'(cnt1), 32'd0);
    rst_mmm = 1'b1;

    // clear together with load: clear wins
    drive(1, 1, 10'h3FF);
    rst_mmm = 1'b0;
    cycle("clr_vs_load");
    do_chk("clr_vs_load.busy", 32'(if1.busy), 32'd0);
    rst_mmm = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      rst_mmm = ($urandom_range(0, 19) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            10'($urandom_range(0, 1023)));
      cycle("rand");
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
